gate_pattern_sweeper: RTL and testbench
=======================================

Name: gate_pattern_sweeper

Overview:
- Parametrised, synthesizable successor to the 4-input gate exercise and its toggling-input bench.
- Sweeps all 2^N_IN input combinations, in binary or Gray order, at a programmable dwell per pattern.
- Drives the pattern onto a gate under test and produces a registered reference reduction (OR/AND/XOR/NOR) plus a popcount.
- Sits between board switches/start button and the lab gate logic, for on-board exhaustive truth-table checking.

Parameters:
- N_IN, 4, number of gate inputs (2..16).
- STEP_CYCLES, 20, clock cycles each pattern is held (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin sweep; honoured in IDLE and DONE only.
- pause  input  1  level; freezes sweep while high.
- abort  input  1  return to IDLE.
- mode  input  2  reference function: 00 OR, 01 AND, 10 XOR, 11 NOR.
- seq_sel  input  1  0 = binary order, 1 = Gray order (one bit toggles per step).
- pattern  output  N_IN  current input pattern.
- pat_strobe  output  1  one-cycle pulse when pattern updates.
- gate_out  output  1  registered reference reduction of pattern.
- gate_valid  output  1  one-cycle pulse when gate_out updates.
- ones_cnt  output  clog2(N_IN+1)  number of 1s in pattern, registered with gate_out.
- busy  output  1  high in RUN or HOLD.
- done  output  1  high in DONE.

Behaviour:
- Reset (async): state IDLE; pattern, idx, step_cnt, gate_out, ones_cnt, pat_strobe, gate_valid, busy, done all 0. Outputs clear immediately, not at the next edge.
- State IDLE:
  - start=1 → RUN next edge.
  - On that edge: idx=0, step_cnt=0, pattern=0, pat_strobe=1.
  - mode and seq_sel are captured into internal registers; later changes are ignored until the next start.
- State RUN:
  - step_cnt increments each cycle.
  - At step_cnt==STEP_CYCLES-1 with idx<2^N_IN-1: step_cnt=0, idx++, pattern=seq(idx+1), pat_strobe=1.
  - At step_cnt==STEP_CYCLES-1 with idx==2^N_IN-1: → DONE; pattern holds.
  - seq(k) = k when seq_sel=0; k^(k>>1) when seq_sel=1.
- State HOLD:
  - Entered from RUN when pause=1; step_cnt, idx and pattern are frozen.
  - pause=0 → RUN; counting resumes from the frozen step_cnt.
  - No dwell cycles are lost or added, other than the paused ones.
- State DONE:
  - done=1; pattern, gate_out and ones_cnt hold.
  - start → RUN with the same init as from IDLE; done clears on that edge.
- abort (any non-reset state) → IDLE next edge, with all outputs cleared as at reset.
- Priority: rst > abort > pause > step/start. Start is ignored in RUN/HOLD. Pause in IDLE/DONE is ignored.
- Latency:
  - gate_out, ones_cnt and gate_valid update one edge after the pattern edge.
  - gate_valid is pat_strobe delayed by one cycle.
  - gate_out keeps its last value between updates.
- Arithmetic/widths:
  - idx width N_IN; last index is all-ones.
  - step_cnt width max(1, clog2(STEP_CYCLES)).
  - STEP_CYCLES=1 gives a new pattern every cycle, with pat_strobe held high through RUN.
- Timing: start edge t0 → done rises at edge t0 + 2^N_IN*STEP_CYCLES + (paused cycles). busy falls on the same edge.

Test Plan:
- N_IN=4, STEP=20, mode OR, binary, start at t0:
  - pattern 0000 for 20 cycles; gate_out=0 at t0+1.
  - pattern 0001 at t0+20; gate_out=1 at t0+21.
  - done at t0+320; pattern 1111; ones_cnt=4.
- N_IN=4, Gray, mode XOR:
  - pattern sequence 0000,0001,0011,0010,0110…; exactly one bit changes per step.
  - gate_out alternates 0,1,0,1 per step; final pattern 1000; done at t0+320.
- N_IN=4, STEP=20, pause high for 5 cycles starting at t0+10:
  - busy stays 1; pattern 0001 appears at t0+25; done at t0+325.
  - start pulsed during RUN changes nothing.
- abort at t0+100, with pause also high that cycle:
  - next edge: IDLE; pattern=0000; gate_out=0; busy=0; done=0.
  - a later start sweeps again from 0000.
- N_IN=2, STEP=1, mode AND:
  - patterns 00,01,10,11 on consecutive edges t0..t0+3; gate_out 0,0,0,1 one cycle later.
  - done at t0+4. Then NOR restart: gate_out 1,0,0,0.
- rst asserted mid-RUN between clock edges: all outputs 0 before the next edge; IDLE after release; mode change mid-run has no effect on gate_out.

Source files
------------

// File: rtl/gate_pattern_sweeper.sv
// Exhaustive input-pattern sweeper for a gate under test: steps all 2^N_IN
// patterns (binary or Gray) with a fixed dwell and emits a registered reference.
module gate_pattern_sweeper #(
  parameter int N_IN        = 4,
  parameter int STEP_CYCLES = 20,
  localparam int CW = $clog2(N_IN + 1),
  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            pause,
  input  logic            abort,
  input  logic [1:0]      mode,
  input  logic            seq_sel,
  output logic [N_IN-1:0] pattern,
  output logic            pat_strobe,
  output logic            gate_out,
  output logic            gate_valid,
  output logic [CW-1:0]   ones_cnt,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  localparam logic [SW-1:0] LAST_STEP = SW'(STEP_CYCLES - 1);

  state_t          state;
  logic [N_IN-1:0] idx;
  logic [SW-1:0]   step_cnt;
  logic [1:0]      mode_r;
  logic            seq_r;

  function automatic logic [N_IN-1:0] seq_f(input logic [N_IN-1:0] k, input logic gray);
    return gray ? (k ^ (k >> 1)) : k;
  endfunction

  function automatic logic reduce_f(input logic [N_IN-1:0] p, input logic [1:0] m);
    case (m)
      2'b00:   return |p;
      2'b01:   return &p;
      2'b10:   return ^p;
      default: return ~|p;
    endcase
  endfunction

  function automatic logic [CW-1:0] popcnt_f(input logic [N_IN-1:0] p);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N_IN; i++) c = c + CW'(p[i]);
    return c;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pattern    <= '0;
      idx        <= '0;
      step_cnt   <= '0;
      gate_out   <= 1'b0;
      ones_cnt   <= '0;
      pat_strobe <= 1'b0;
      gate_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mode_r     <= 2'b00;
      seq_r      <= 1'b0;
    end else begin
      pat_strobe <= 1'b0;
      gate_valid <= pat_strobe;
      // Reference follows the pattern by exactly one edge.
      if (pat_strobe) begin
        gate_out <= reduce_f(pattern, mode_r);
        ones_cnt <= popcnt_f(pattern);
      end
      if (abort) begin
        state      <= IDLE;
        pattern    <= '0;
        idx        <= '0;
        step_cnt   <= '0;
        gate_out   <= 1'b0;
        ones_cnt   <= '0;
        pat_strobe <= 1'b0;
        gate_valid <= 1'b0;
        busy       <= 1'b0;
        done       <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              state      <= RUN;
              idx        <= '0;
              step_cnt   <= '0;
              pattern    <= '0;
              pat_strobe <= 1'b1;
              busy       <= 1'b1;
              done       <= 1'b0;
              mode_r     <= mode;
              seq_r      <= seq_sel;
            end
          end
          RUN, HOLD: begin
            if (pause) begin
              state <= HOLD;
            end else begin
              // Leaving HOLD counts this cycle so only paused cycles stretch the dwell.
              state <= RUN;
              if (step_cnt == LAST_STEP) begin
                if (idx == '1) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end else begin
                  step_cnt   <= '0;
                  idx        <= idx + 1'b1;
                  pattern    <= seq_f(idx + 1'b1, seq_r);
                  pat_strobe <= 1'b1;
                end
              end else begin
                step_cnt <= step_cnt + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gate_pattern_sweeper.sv
// Directed bench for gate_pattern_sweeper: a 4-input/20-cycle instance and a
// 2-input/1-cycle instance, checked at hand-computed cycle offsets from start.
module tb_gate_pattern_sweeper;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       a_start = 0, a_pause = 0, a_abort = 0, a_seq = 0;
  logic [1:0] a_mode = 0;
  logic [3:0] a_pattern;
  logic       a_strobe, a_gout, a_gval, a_busy, a_done;
  logic [2:0] a_ones;

  logic       b_start = 0, b_pause = 0, b_abort = 0, b_seq = 0;
  logic [1:0] b_mode = 0;
  logic [1:0] b_pattern;
  logic       b_strobe, b_gout, b_gval, b_busy, b_done;
  logic [1:0] b_ones;

  gate_pattern_sweeper #(.N_IN(4), .STEP_CYCLES(20)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .pause(a_pause), .abort(a_abort),
    .mode(a_mode), .seq_sel(a_seq), .pattern(a_pattern), .pat_strobe(a_strobe),
    .gate_out(a_gout), .gate_valid(a_gval), .ones_cnt(a_ones), .busy(a_busy), .done(a_done));

  gate_pattern_sweeper #(.N_IN(2), .STEP_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .pause(b_pause), .abort(b_abort),
    .mode(b_mode), .seq_sel(b_seq), .pattern(b_pattern), .pat_strobe(b_strobe),
    .gate_out(b_gout), .gate_valid(b_gval), .ones_cnt(b_ones), .busy(b_busy), .done(b_done));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic adv(input int n);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({a_pattern, a_strobe, a_gout, a_gval, a_ones, a_busy, a_done} !== 12'h000) begin
      errors++; $display("FAIL reset_a: got %h want 000", {a_pattern, a_strobe, a_gout, a_gval, a_ones, a_busy, a_done});
    end
    checks++;
    if ({b_pattern, b_strobe, b_gout, b_gval, b_ones, b_busy, b_done} !== 9'h000) begin
      errors++; $display("FAIL reset_b: got %h want 000", {b_pattern, b_strobe, b_gout, b_gval, b_ones, b_busy, b_done});
    end
    adv(2);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_binary_or();
    a_mode = 2'b00; a_seq = 1'b0; a_start = 1'b1;
    tick(); a_start = 1'b0;                       // t0
    checks++;
    if ({a_pattern, a_strobe, a_busy, a_done} !== 7'b0000_110) begin
      errors++; $display("FAIL or_t0: got %b want 0000110", {a_pattern, a_strobe, a_busy, a_done});
    end
    tick();                                       // t0+1
    checks++;
    if ({a_gout, a_gval, a_strobe} !== 3'b010) begin
      errors++; $display("FAIL or_t1_gate: got %b want 010", {a_gout, a_gval, a_strobe});
    end
    adv(18);                                      // t0+19
    checks++;
    if ({a_pattern, a_strobe} !== 5'b0000_0) begin
      errors++; $display("FAIL or_t19_hold: got %b want 00000", {a_pattern, a_strobe});
    end
    tick();                                       // t0+20
    checks++;
    if ({a_pattern, a_strobe} !== 5'b0001_1) begin
      errors++; $display("FAIL or_t20_step: got %b want 00011", {a_pattern, a_strobe});
    end
    tick();                                       // t0+21
    checks++;
    if ({a_gout, a_gval, a_ones} !== 5'b11_001) begin
      errors++; $display("FAIL or_t21_gate: got %b want 11001", {a_gout, a_gval, a_ones});
    end
    adv(298);                                     // t0+319
    checks++;
    if ({a_pattern, a_busy, a_done} !== 6'b1111_10) begin
      errors++; $display("FAIL or_t319: got %b want 111110", {a_pattern, a_busy, a_done});
    end
    tick();                                       // t0+320
    checks++;
    if ({a_pattern, a_busy, a_done} !== 6'b1111_01) begin
      errors++; $display("FAIL or_t320_done: got %b want 111101", {a_pattern, a_busy, a_done});
    end
    tick();                                       // t0+321
    checks++;
    if ({a_ones, a_gout, a_done, a_pattern} !== 9'b100_1_1_1111) begin
      errors++; $display("FAIL or_final_hold: got %b want 100111111", {a_ones, a_gout, a_done, a_pattern});
    end
  endtask

  task automatic test_gray_xor();
    logic [3:0] gray [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                              4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    logic [3:0] prev;
    prev = 4'h0;
    a_mode = 2'b10; a_seq = 1'b1; a_start = 1'b1;
    tick(); a_start = 1'b0;                       // t0 (restart from DONE)
    a_mode = 2'b00; a_seq = 1'b0;                 // must be ignored mid-run
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (a_pattern !== gray[k]) begin
        errors++; $display("FAIL gray_pattern[%0d]: got %h want %h", k, a_pattern, gray[k]);
      end
      if (k > 0) begin
        checks++;
        if ($countones(a_pattern ^ prev) != 1) begin
          errors++; $display("FAIL gray_onebit[%0d]: got %h after %h want one bit change", k, a_pattern, prev);
        end
      end
      prev = a_pattern;
      tick();
      checks++;
      if (a_gout !== 1'(k % 2)) begin
        errors++; $display("FAIL gray_xor[%0d]: got %b want %b", k, a_gout, 1'(k % 2));
      end
      adv(19);
    end
    checks++;                                     // t0+320
    if ({a_pattern, a_done, a_busy} !== 6'b1000_10) begin
      errors++; $display("FAIL gray_done: got %b want 100010", {a_pattern, a_done, a_busy});
    end
  endtask

  task automatic test_pause();
    a_mode = 2'b00; a_seq = 1'b0; a_start = 1'b1;
    tick(); a_start = 1'b0;                       // t0
    adv(3); a_start = 1'b1;
    tick(); a_start = 1'b0;                       // t0+4: start ignored in RUN
    checks++;
    if ({a_pattern, a_busy, a_strobe} !== 6'b0000_10) begin
      errors++; $display("FAIL pause_start_ignored: got %b want 000010", {a_pattern, a_busy, a_strobe});
    end
    adv(5); a_pause = 1'b1;                       // t0+9
    adv(3);                                       // t0+12
    checks++;
    if ({a_pattern, a_busy, a_done} !== 6'b0000_10) begin
      errors++; $display("FAIL pause_busy: got %b want 000010", {a_pattern, a_busy, a_done});
    end
    adv(2); a_pause = 1'b0;                       // t0+14
    adv(10);                                      // t0+24
    checks++;
    if (a_pattern !== 4'h0) begin
      errors++; $display("FAIL pause_t24: got %h want 0", a_pattern);
    end
    tick();                                       // t0+25
    checks++;
    if ({a_pattern, a_strobe} !== 5'b0001_1) begin
      errors++; $display("FAIL pause_t25: got %b want 00011", {a_pattern, a_strobe});
    end
    adv(299);                                     // t0+324
    checks++;
    if ({a_busy, a_done} !== 2'b10) begin
      errors++; $display("FAIL pause_t324: got %b want 10", {a_busy, a_done});
    end
    tick();                                       // t0+325
    checks++;
    if ({a_busy, a_done, a_pattern} !== 6'b01_1111) begin
      errors++; $display("FAIL pause_t325_done: got %b want 011111", {a_busy, a_done, a_pattern});
    end
  endtask

  task automatic test_abort_and_async_reset();
    a_mode = 2'b00; a_seq = 1'b0; a_start = 1'b1;
    tick(); a_start = 1'b0;                       // t0
    adv(98);                                      // t0+98
    checks++;
    if ({a_pattern, a_gout, a_busy} !== 6'b0100_11) begin
      errors++; $display("FAIL abort_pre: got %b want 010011", {a_pattern, a_gout, a_busy});
    end
    tick(); a_abort = 1'b1; a_pause = 1'b1;       // t0+99
    tick();                                       // t0+100
    a_abort = 1'b0; a_pause = 1'b0;
    checks++;
    if ({a_pattern, a_gout, a_busy, a_done, a_strobe, a_gval, a_ones} !== 12'h000) begin
      errors++; $display("FAIL abort_clear: got %b want 0", {a_pattern, a_gout, a_busy, a_done, a_strobe, a_gval, a_ones});
    end
    tick();
    checks++;
    if ({a_busy, a_strobe} !== 2'b00) begin
      errors++; $display("FAIL abort_idle: got %b want 00", {a_busy, a_strobe});
    end
    a_start = 1'b1;
    tick(); a_start = 1'b0;                       // t0'
    checks++;
    if ({a_pattern, a_busy, a_strobe} !== 6'b0000_11) begin
      errors++; $display("FAIL abort_restart: got %b want 000011", {a_pattern, a_busy, a_strobe});
    end
    adv(20);                                      // t0'+20
    checks++;
    if (a_pattern !== 4'h1) begin
      errors++; $display("FAIL abort_restart_step: got %h want 1", a_pattern);
    end
    adv(30);                                      // t0'+50
    a_mode = 2'b01;                               // mid-run change must not alter gate_out
    checks++;
    if ({a_pattern, a_gout, a_busy} !== 6'b0010_11) begin
      errors++; $display("FAIL rst_pre: got %b want 001011", {a_pattern, a_gout, a_busy});
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({a_pattern, a_strobe, a_gout, a_gval, a_ones, a_busy, a_done} !== 12'h000) begin
      errors++; $display("FAIL rst_async: got %b want 0", {a_pattern, a_strobe, a_gout, a_gval, a_ones, a_busy, a_done});
    end
    @(negedge clk); rst = 1'b0;
    tick(); tick();
    checks++;
    if ({a_pattern, a_busy, a_done, a_strobe} !== 7'b0) begin
      errors++; $display("FAIL rst_idle: got %b want 0", {a_pattern, a_busy, a_done, a_strobe});
    end
    a_mode = 2'b00;
  endtask

  task automatic test_short_and_nor();
    logic [1:0] exp_pat [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    logic       exp_and [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       exp_nor [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       exp_dn  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int r = 0; r < 2; r++) begin
      b_mode = (r == 0) ? 2'b01 : 2'b11; b_start = 1'b1;
      tick(); b_start = 1'b0;                     // t0
      for (int k = 0; k < 5; k++) begin
        checks++;
        if ({b_pattern, b_done, b_busy} !== {exp_pat[k], exp_dn[k], ~exp_dn[k]}) begin
          errors++; $display("FAIL short_state r%0d[%0d]: got %b want %b", r, k,
                             {b_pattern, b_done, b_busy}, {exp_pat[k], exp_dn[k], ~exp_dn[k]});
        end
        if (k > 0) begin
          checks++;
          if (b_gout !== ((r == 0) ? exp_and[k] : exp_nor[k])) begin
            errors++; $display("FAIL short_gate r%0d[%0d]: got %b want %b", r, k, b_gout,
                               (r == 0) ? exp_and[k] : exp_nor[k]);
          end
        end
        if (k < 5 - 1) tick();
      end
      checks++;
      if ({b_ones, b_strobe} !== 3'b10_0) begin
        errors++; $display("FAIL short_ones r%0d: got %b want 100", r, {b_ones, b_strobe});
      end
    end
  endtask

  initial begin
    test_reset();
    test_binary_or();
    test_gray_xor();
    test_pause();
    test_abort_and_async_reset();
    test_short_and_nor();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
